router_in_port: RTL and testbench

ROUTER_IN_PORT -- requirements
Module: router_in_port

---
 rtl/router_pkg.sv | 18 +
 rtl/router_flit_fifo.sv | 55 +++++
 rtl/router_in_port.sv | 86 ++++++++
 tb/tb_router_in_port.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the router input port: default widths, flit record and port FSM states.
package router_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 8;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2
    } port_state_t;

endpackage

// File: rtl/router_flit_fifo.sv
// Flit buffer for one router input port: power-of-two ring with occupancy counter.
module router_flit_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    // Storage carries no reset; validity is tracked solely by the counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_DEPTH);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/router_in_port.sv
// Router input port: buffers flits, requests a route for the head packet, then forwards it.
module router_in_port
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              route_req,
    output logic [DEST_W-1:0] route_dest,
    input  logic              route_grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    port_state_t   state_reg;
    logic          ready_en_reg;
    logic          push;
    logic          pop;
    logic [DATA_W:0] head;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          in_fwd;
    logic          more_left;

    router_flit_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_last, in_data}),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // ready_en_reg keeps in_ready low through reset and until the first edge after release.
    assign in_ready  = ready_en_reg && !full;
    assign push      = in_valid && in_ready;
    assign in_fwd    = (state_reg == ST_FWD);
    assign out_valid = in_fwd && !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = in_fwd ? head[DATA_W-1:0] : '0;
    assign out_last  = in_fwd && head[DATA_W];
    assign route_req = (state_reg == ST_REQ);
    assign route_dest = route_req ? head[DEST_W-1:0] : '0;

    // A flit written on the same edge as the tail pop also counts as the next packet's head.
    assign more_left = (count > CNT_ONE) || push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: if (!empty)      state_reg <= ST_REQ;
                ST_REQ:  if (route_grant) state_reg <= ST_FWD;
                ST_FWD: begin
                    if (pop && head[DATA_W]) begin
                        state_reg <= more_left ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_in_port.sv
// Bench for router_in_port: scoreboard on flit order plus table-driven and hand-written route sequences.
module tb_router_in_port;
    import router_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEST_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              route_req;
    logic [DEST_W-1:0] route_dest;
    logic              route_grant = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    int total  = 0;
    int passed = 0;
    flit_t sb[$];

    typedef struct {
        logic [31:0] hdr;
        int          nflits;
        int          gdelay;
        logic [7:0]  exp_dest;
    } vec_t;

    router_in_port #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .route_req   (route_req),
        .route_dest  (route_dest),
        .route_grant (route_grant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %s: got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: record accepted input, compare any popped flit against the scoreboard.
    task automatic tick();
        flit_t f;
        #1;
        if (in_valid && in_ready) begin
            f.data = in_data;
            f.last = in_last;
            sb.push_back(f);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", out_valid, 1'b0);
            end else begin
                f = sb.pop_front();
                check("out_data", out_data, f.data);
                check("out_last", out_last, f.last);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] d, logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while (sb.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic wait_req(int maxc);
        int n = 0;
        while (!route_req && n < maxc) begin
            tick();
            n++;
        end
        check("route_req_seen", route_req, 1'b1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_route_req"}, route_req, 1'b0);
        check({tag, "_route_dest"}, route_dest, 8'h00);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_last"}, out_last, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_in_ready_post", in_ready, 1'b1);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{hdr: 32'h1234_56AB, nflits: 2, gdelay: 0, exp_dest: 8'hAB};
        vecs[1] = '{hdr: 32'hFFFF_FF00, nflits: 1, gdelay: 3, exp_dest: 8'h00};
        vecs[2] = '{hdr: 32'h0000_0080, nflits: 3, gdelay: 1, exp_dest: 8'h80};
        vecs[3] = '{hdr: 32'hCAFE_BE7F, nflits: 4, gdelay: 2, exp_dest: 8'h7F};

        // Reset state
        #13;
        check_all_zero("reset");
        release_reset();

        // 3-flit packet, header 5, grant two cycles after route_req
        out_ready = 1'b1;
        drive(32'h0000_0005, 1'b0); tick();
        check("a_req_latency", route_req, 1'b0);
        drive(32'h0000_00A1, 1'b0); tick();
        check("a_req1", route_req, 1'b1);
        check("a_dest1", route_dest, 8'h05);
        drive(32'h0000_00A2, 1'b1); tick();
        check("a_dest2", route_dest, 8'h05);
        idle_in(); tick();
        check("a_dest3", route_dest, 8'h05);
        check("a_noval_in_req", out_valid, 1'b0);
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        check("a_fwd_req", route_req, 1'b0);
        check("a_fwd_dest", route_dest, 8'h00);
        check("a_fwd_valid", out_valid, 1'b1);
        drain(10);
        check("a_idle_valid", out_valid, 1'b0);
        check("a_idle_req", route_req, 1'b0);

        // Table of packets with varied headers, lengths and grant delays
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            for (int j = 0; j < vecs[i].nflits; j++) begin
                drive((j == 0) ? vecs[i].hdr : {vecs[i].hdr[15:0], 16'(j)},
                      (j == vecs[i].nflits - 1));
                tick();
            end
            idle_in();
            wait_req(8);
            check("t_dest", route_dest, vecs[i].exp_dest);
            check("t_noval", out_valid, 1'b0);
            for (int k = 0; k < vecs[i].gdelay; k++) begin
                tick();
                check("t_req_hold", route_req, 1'b1);
            end
            route_grant = 1'b1; tick(); route_grant = 1'b0;
            check("t_fwd_valid", out_valid, 1'b1);
            drain(20);
            check("t_end_req", route_req, 1'b0);
            check("t_end_valid", out_valid, 1'b0);
        end

        // Fill to DEPTH with no grant; fifth flit refused
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? 32'h0000_0042 : 32'h0000_00B0 + i, (i == 3));
            tick();
            check("b_in_ready", in_ready, (i < 3));
        end
        drive(32'h0000_DEAD, 1'b1); tick();
        check("b_fifth_refused", in_ready, 1'b0);
        idle_in();
        check("b_dest", route_dest, 8'h42);
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        out_ready = 1'b1;
        drain(10);
        check("b_no_extra_valid", out_valid, 1'b0);
        check("b_no_extra_req", route_req, 1'b0);

        // Back-to-back single-flit packets: FWD goes straight to REQ
        drive(32'h0000_0001, 1'b1); tick();
        drive(32'h0000_0002, 1'b1); tick();
        idle_in();
        check("c_req1", route_req, 1'b1);
        check("c_dest1", route_dest, 8'h01);
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        check("c_fwd1_last", out_last, 1'b1);
        tick();
        check("c_fwd_to_req", route_req, 1'b1);
        check("c_dest2", route_dest, 8'h02);
        check("c_req2_noval", out_valid, 1'b0);
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        drain(5);
        check("c_idle_req", route_req, 1'b0);

        // Grant while idle is ignored
        route_grant = 1'b1; tick(); tick(); route_grant = 1'b0;
        check("d_idle_req", route_req, 1'b0);
        check("d_idle_valid", out_valid, 1'b0);
        drive(32'h0000_0033, 1'b1); tick();
        idle_in(); tick();
        check("d_req_after", route_req, 1'b1);
        check("d_not_fwd", out_valid, 1'b0);
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        drain(5);

        // Simultaneous push and pop at occupancy 2 keeps occupancy
        out_ready = 1'b0;
        drive(32'h0000_0007, 1'b0); tick();
        drive(32'h0000_00E1, 1'b0); tick();
        idle_in();
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        check("e_fwd_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        drive(32'h0000_00E2, 1'b0); tick();
        out_ready = 1'b0;
        check("e_sb_occ2", sb.size(), 2);
        drive(32'h0000_00E3, 1'b0); tick();
        check("e_occ3_ready", in_ready, 1'b1);
        drive(32'h0000_00E4, 1'b1); tick();
        check("e_occ4_ready", in_ready, 1'b0);
        idle_in();
        out_ready = 1'b1;
        drain(10);
        check("e_end_valid", out_valid, 1'b0);

        // Reset after 2 of 3 flits forwarded
        out_ready = 1'b0;
        drive(32'h0000_0009, 1'b0); tick();
        drive(32'h0000_00F1, 1'b0); tick();
        drive(32'h0000_00F2, 1'b1); tick();
        idle_in();
        route_grant = 1'b1; tick(); route_grant = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        check("f_third_offered", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("f_async");
        sb.delete();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("f_no_leftover", out_valid, 1'b0);
        end
        check("f_no_req", route_req, 1'b0);
        check("f_ready", in_ready, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
